// File: rtl/mem_pkg.sv
// Shared decode constants, size codes and FSM state type for the memory-access stage.
package mem_pkg;

   localparam int unsigned OP_W     = 5;
   localparam int unsigned OP_MEM   = 4;
   localparam int unsigned OP_STORE = 3;
   localparam int unsigned OP_UNS   = 2;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2,
      SZ_D = 2'd3
   } mem_size_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_REQ2,
      ST_DONE
   } mem_state_e;

   function automatic int unsigned lanes_of(input int unsigned xlen);
      return xlen / 8;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane alignment over a two-word window: store direction shifts data onto lanes,
// load direction shifts merged lanes down and sign/zero-extends to XLEN.
module mem_lane_align
   import mem_pkg::*;
#(
   parameter int unsigned XLEN     = 32,
   parameter bit          LOAD_DIR = 1'b0
) (
   input  logic [$clog2(XLEN/8)-1:0] off_i,
   input  logic [1:0]                size_i,
   input  logic                      uns_i,
   input  logic [2*XLEN-1:0]         data_i,
   output logic [2*XLEN/8-1:0]       mask_o,
   output logic [2*XLEN-1:0]         data_o
);

   localparam int unsigned NB = lanes_of(XLEN);
   localparam int unsigned OW = $clog2(NB);
   localparam int unsigned W2 = 2 * XLEN;
   localparam int unsigned M2 = 2 * NB;

   logic [6:0]    nbits;
   logic [OW+2:0] sh;
   logic [W2-1:0] width_mask;
   logic [W2-1:0] top_bit;
   logic [W2-1:0] raw;
   logic [W2-1:0] ext;
   logic [W2-1:0] st_v;

   always_comb begin
      nbits      = 7'd8 << size_i;
      sh         = {off_i, 3'b000};
      width_mask = (W2'(1) << nbits) - W2'(1);
      top_bit    = width_mask ^ (width_mask >> 1);
      mask_o     = ((M2'(1) << (4'd1 << size_i)) - M2'(1)) << off_i;

      st_v = ({{XLEN{1'b0}}, data_i[XLEN-1:0]} & width_mask) << sh;

      // lanes of a split load are already merged in data_i, so extension sees the full value
      raw = data_i >> sh;
      ext = raw & width_mask;
      if (!uns_i && ((raw & top_bit) != '0)) begin
         ext = ext | ~width_mask;
      end

      data_o = LOAD_DIR ? (ext & {{XLEN{1'b0}}, {XLEN{1'b1}}}) : st_v;
   end

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store stage over a valid/ack bus; stalls the pipeline until done.
// Define MISALIGN_SPLIT_EN to split word-crossing accesses into two beats instead of trapping.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int unsigned XLEN = 32,
   parameter int unsigned AW   = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [OP_W-1:0]     mem_op_i,
   input  logic [AW-1:0]       mem_addr_i,
   input  logic                w_enable_i,
   input  logic [4:0]          w_addr_i,
   input  logic [XLEN-1:0]     w_data_i,
   output logic                w_enable_o,
   output logic [4:0]          w_addr_o,
   output logic [XLEN-1:0]     w_data_o,
   output logic                stall_req_o,
   output logic                misalign_o,
   output logic                bus_req_o,
   output logic                bus_we_o,
   output logic [AW-1:0]       bus_addr_o,
   output logic [XLEN/8-1:0]   bus_sel_o,
   output logic [XLEN-1:0]     bus_wdata_o,
   input  logic                bus_ack_i,
   input  logic [XLEN-1:0]     bus_rdata_i
);

   localparam int unsigned NB = lanes_of(XLEN);
   localparam int unsigned OW = $clog2(NB);
   localparam int unsigned W2 = 2 * XLEN;

   logic            is_mem, is_store, uns;
   logic [1:0]      size;
   logic [OW-1:0]   off;
   logic [AW-1:0]   word_addr;
   logic            unsupported, fatal, split;
   logic [2*NB-1:0] st_mask, ld_mask;
   logic [W2-1:0]   st_data, ld_data;
   logic [XLEN-1:0] ld_hi_unused;
   logic [NB-1:0]   lane_sel;
   logic [XLEN-1:0] beat_d;

   mem_state_e      state_q;
   logic [W2-1:0]   raw_q;
   logic            breq_q, bwe_q, mis_q;
   logic [AW-1:0]   baddr_q;
   logic [NB-1:0]   bsel_q;
   logic [XLEN-1:0] bwdata_q;

   assign is_mem       = mem_op_i[OP_MEM];
   assign is_store     = mem_op_i[OP_STORE];
   assign uns          = mem_op_i[OP_UNS];
   assign size         = mem_op_i[1:0];
   assign off          = mem_addr_i[OW-1:0];
   assign word_addr    = {mem_addr_i[AW-1:OW], {OW{1'b0}}};
   assign unsupported  = (XLEN == 32) && (size == SZ_D);
   assign ld_hi_unused = ld_data[W2-1:XLEN];

`ifdef MISALIGN_SPLIT_EN
   assign fatal = unsupported;
   assign split = |st_mask[2*NB-1:NB];
`else
   assign fatal = unsupported || ((mem_addr_i[2:0] & ((3'd1 << size) - 3'd1)) != 3'b000);
   assign split = 1'b0;
`endif

   mem_lane_align #(.XLEN(XLEN), .LOAD_DIR(1'b0)) u_store_align (
      .off_i  (off),
      .size_i (size),
      .uns_i  (1'b0),
      .data_i ({{XLEN{1'b0}}, w_data_i}),
      .mask_o (st_mask),
      .data_o (st_data)
   );

   mem_lane_align #(.XLEN(XLEN), .LOAD_DIR(1'b1)) u_load_align (
      .off_i  (off),
      .size_i (size),
      .uns_i  (uns),
      .data_i (raw_q),
      .mask_o (ld_mask),
      .data_o (ld_data)
   );

   always_comb begin
      beat_d   = '0;
      lane_sel = (state_q == ST_REQ2) ? ld_mask[2*NB-1:NB] : ld_mask[NB-1:0];
      for (int unsigned k = 0; k < NB; k++) begin
         if (lane_sel[k]) beat_d[8*k +: 8] = bus_rdata_i[8*k +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         raw_q    <= '0;
         breq_q   <= 1'b0;
         bwe_q    <= 1'b0;
         baddr_q  <= '0;
         bsel_q   <= '0;
         bwdata_q <= '0;
         mis_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               mis_q <= 1'b0;
               if (is_mem) begin
                  if (fatal) begin
                     state_q <= ST_DONE;
                     mis_q   <= 1'b1;
                  end else begin
                     state_q  <= ST_REQ;
                     breq_q   <= 1'b1;
                     bwe_q    <= is_store;
                     baddr_q  <= word_addr;
                     bsel_q   <= st_mask[NB-1:0];
                     bwdata_q <= is_store ? st_data[XLEN-1:0] : '0;
                  end
               end
            end
            ST_REQ: begin
               if (bus_ack_i) begin
                  raw_q <= {{XLEN{1'b0}}, beat_d};
                  if (split) begin
                     state_q  <= ST_REQ2;
                     baddr_q  <= word_addr + AW'(NB);
                     bsel_q   <= st_mask[2*NB-1:NB];
                     bwdata_q <= is_store ? st_data[W2-1:XLEN] : '0;
                  end else begin
                     state_q  <= ST_DONE;
                     breq_q   <= 1'b0;
                     bwe_q    <= 1'b0;
                     baddr_q  <= '0;
                     bsel_q   <= '0;
                     bwdata_q <= '0;
                  end
               end
            end
            ST_REQ2: begin
               if (bus_ack_i) begin
                  raw_q[W2-1:XLEN] <= beat_d;
                  state_q  <= ST_DONE;
                  breq_q   <= 1'b0;
                  bwe_q    <= 1'b0;
                  baddr_q  <= '0;
                  bsel_q   <= '0;
                  bwdata_q <= '0;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               mis_q   <= 1'b0;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // reset forces every output low combinationally, even mid-access
   always_comb begin
      w_enable_o  = 1'b0;
      w_addr_o    = '0;
      w_data_o    = '0;
      stall_req_o = 1'b0;
      misalign_o  = 1'b0;
      bus_req_o   = 1'b0;
      bus_we_o    = 1'b0;
      bus_addr_o  = '0;
      bus_sel_o   = '0;
      bus_wdata_o = '0;
      if (!rst) begin
         misalign_o  = mis_q;
         bus_req_o   = breq_q;
         bus_we_o    = bwe_q;
         bus_addr_o  = baddr_q;
         bus_sel_o   = bsel_q;
         bus_wdata_o = bwdata_q;
         if (state_q == ST_IDLE && !is_mem) begin
            w_enable_o = w_enable_i;
            w_addr_o   = w_addr_i;
            w_data_o   = w_data_i;
         end else begin
            w_addr_o    = w_addr_i;
            stall_req_o = (state_q != ST_DONE);
            if (state_q == ST_DONE && !mis_q) begin
               w_enable_o = w_enable_i & ~is_store;
               w_data_o   = is_store ? '0 : ld_data[XLEN-1:0];
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (XLEN=32): loads, stores, misalign, reset, pass-through.
module tb_mem_access_unit;

   localparam logic [4:0] OP_NONE = 5'b00000;
   localparam logic [4:0] OP_LW   = 5'b10010;
   localparam logic [4:0] OP_LB   = 5'b10000;
   localparam logic [4:0] OP_LBU  = 5'b10100;
   localparam logic [4:0] OP_SH   = 5'b11001;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  mem_op;
   logic [31:0] mem_addr;
   logic        w_en_i;
   logic [4:0]  w_addr_i;
   logic [31:0] w_data_i;
   logic        w_en_o;
   logic [4:0]  w_addr_o;
   logic [31:0] w_data_o;
   logic        stall;
   logic        misalign;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_sel;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   int total = 0;
   int bad   = 0;

   mem_access_unit #(.XLEN(32), .AW(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .mem_op_i    (mem_op),
      .mem_addr_i  (mem_addr),
      .w_enable_i  (w_en_i),
      .w_addr_i    (w_addr_i),
      .w_data_i    (w_data_i),
      .w_enable_o  (w_en_o),
      .w_addr_o    (w_addr_o),
      .w_data_o    (w_data_o),
      .stall_req_o (stall),
      .misalign_o  (misalign),
      .bus_req_o   (bus_req),
      .bus_we_o    (bus_we),
      .bus_addr_o  (bus_addr),
      .bus_sel_o   (bus_sel),
      .bus_wdata_o (bus_wdata),
      .bus_ack_i   (bus_ack),
      .bus_rdata_i (bus_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   task automatic nxt;
      @(posedge clk);
      #1;
   endtask

   task automatic smp;
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; mem_op = OP_NONE; mem_addr = '0; w_en_i = 1'b0; w_addr_i = '0;
      w_data_i = '0; bus_ack = 1'b0; bus_rdata = '0;
      nxt; nxt;
      mem_op = OP_LW; mem_addr = 32'h100; w_en_i = 1'b1; w_addr_i = 5'd7;
      smp;
      chk("rst_stall", stall, 0);
      chk("rst_wen", w_en_o, 0);
      chk("rst_waddr", w_addr_o, 0);
      chk("rst_req", bus_req, 0);

      // LW 0x100, ack in first REQ cycle
      nxt; rst = 1'b0; bus_rdata = 32'hDEADBEEF;
      smp;
      chk("lw_c0_stall", stall, 1);
      chk("lw_c0_req", bus_req, 0);
      chk("lw_c0_wen", w_en_o, 0);
      nxt; bus_ack = 1'b1;
      smp;
      chk("lw_c1_req", bus_req, 1);
      chk("lw_c1_addr", bus_addr, 32'h100);
      chk("lw_c1_sel", bus_sel, 4'b1111);
      chk("lw_c1_we", bus_we, 0);
      chk("lw_c1_stall", stall, 1);
      nxt; bus_ack = 1'b0;
      smp;
      chk("lw_c2_stall", stall, 0);
      chk("lw_c2_wen", w_en_o, 1);
      chk("lw_c2_waddr", w_addr_o, 7);
      chk("lw_c2_wdata", w_data_o, 32'hDEADBEEF);
      chk("lw_c2_req", bus_req, 0);

      // LB 0x103 with one wait cycle, back-to-back after DONE
      nxt; mem_op = OP_LB; mem_addr = 32'h103; bus_rdata = 32'h80112233;
      smp;
      chk("lb_c0_stall", stall, 1);
      nxt;
      smp;
      chk("lb_c1_req", bus_req, 1);
      chk("lb_c1_sel", bus_sel, 4'b1000);
      chk("lb_c1_addr", bus_addr, 32'h100);
      nxt; bus_ack = 1'b1;
      smp;
      chk("lb_wait_req", bus_req, 1);
      chk("lb_wait_sel", bus_sel, 4'b1000);
      chk("lb_wait_stall", stall, 1);
      nxt; bus_ack = 1'b0;
      smp;
      chk("lb_done_wdata", w_data_o, 32'hFFFFFF80);
      chk("lb_done_wen", w_en_o, 1);

      nxt; mem_op = OP_LBU;
      smp;
      chk("lbu_c0_stall", stall, 1);
      nxt; bus_ack = 1'b1;
      smp;
      chk("lbu_c1_req", bus_req, 1);
      nxt; bus_ack = 1'b0;
      smp;
      chk("lbu_done_wdata", w_data_o, 32'h00000080);

      // SH 0x102
      nxt; mem_op = OP_SH; mem_addr = 32'h102; w_data_i = 32'h1234ABCD; w_en_i = 1'b1;
      smp;
      chk("sh_c0_wen", w_en_o, 0);
      chk("sh_c0_stall", stall, 1);
      nxt; bus_ack = 1'b1;
      smp;
      chk("sh_c1_we", bus_we, 1);
      chk("sh_c1_sel", bus_sel, 4'b1100);
      chk("sh_c1_wdata", bus_wdata, 32'hABCD0000);
      chk("sh_c1_addr", bus_addr, 32'h100);
      chk("sh_c1_wen", w_en_o, 0);
      nxt; bus_ack = 1'b0;
      smp;
      chk("sh_done_stall", stall, 0);
      chk("sh_done_wen", w_en_o, 0);
      chk("sh_done_wdata", w_data_o, 0);

      // LW 0x101
      nxt; mem_op = OP_LW; mem_addr = 32'h101; w_data_i = '0;
      smp;
      chk("mis_c0_stall", stall, 1);
      chk("mis_c0_req", bus_req, 0);
`ifndef MISALIGN_SPLIT_EN
      nxt;
      smp;
      chk("mis_c1_misalign", misalign, 1);
      chk("mis_c1_req", bus_req, 0);
      chk("mis_c1_wen", w_en_o, 0);
      chk("mis_c1_stall", stall, 0);
      nxt; mem_op = OP_NONE;
      smp;
      chk("mis_c2_misalign", misalign, 0);
      chk("mis_c2_req", bus_req, 0);
`else
      nxt; bus_ack = 1'b1; bus_rdata = 32'h44332211;
      smp;
      chk("split_b1_req", bus_req, 1);
      chk("split_b1_addr", bus_addr, 32'h100);
      chk("split_b1_sel", bus_sel, 4'b1110);
      chk("split_b1_misalign", misalign, 0);
      nxt; bus_rdata = 32'h88776655;
      smp;
      chk("split_b2_req", bus_req, 1);
      chk("split_b2_addr", bus_addr, 32'h104);
      chk("split_b2_sel", bus_sel, 4'b0001);
      nxt; bus_ack = 1'b0;
      smp;
      chk("split_done_wdata", w_data_o, 32'h55443322);
      chk("split_done_wen", w_en_o, 1);
      nxt; mem_op = OP_NONE;
`endif

      // non-memory pass-through
      mem_op = OP_NONE; w_addr_i = 5'd3; w_data_i = 32'd5; w_en_i = 1'b1;
      smp;
      chk("pass_wen", w_en_o, 1);
      chk("pass_waddr", w_addr_o, 3);
      chk("pass_wdata", w_data_o, 5);
      chk("pass_stall", stall, 0);
      chk("pass_req", bus_req, 0);

      // reset mid-REQ with ack withheld
      nxt; mem_op = OP_LW; mem_addr = 32'h200; w_addr_i = 5'd9; w_data_i = '0;
      smp;
      chk("rreq_c0_stall", stall, 1);
      nxt;
      smp;
      chk("rreq_c1_req", bus_req, 1);
      rst = 1'b1;
      #1;
      chk("rreq_drop_req", bus_req, 0);
      chk("rreq_drop_stall", stall, 0);
      nxt; rst = 1'b0; mem_op = OP_NONE; mem_addr = '0; w_en_i = 1'b0; w_addr_i = '0;
      bus_ack = 1'b1;
      smp;
      chk("rreq_after_req", bus_req, 0);
      chk("rreq_after_stall", stall, 0);
      chk("rreq_after_wen", w_en_o, 0);
      chk("rreq_after_sel", bus_sel, 0);
      chk("rreq_after_misalign", misalign, 0);
      nxt; bus_ack = 1'b0;
      smp;
      chk("rreq_ack_ignored_req", bus_req, 0);
      chk("rreq_ack_ignored_wen", w_en_o, 0);

      // recovery with a fresh load
      nxt; mem_op = OP_LW; mem_addr = 32'h300; w_en_i = 1'b1; w_addr_i = 5'd4;
      bus_rdata = 32'hCAFEF00D;
      smp;
      chk("rec_c0_stall", stall, 1);
      nxt; bus_ack = 1'b1;
      smp;
      chk("rec_c1_addr", bus_addr, 32'h300);
      nxt; bus_ack = 1'b0;
      smp;
      chk("rec_done_wdata", w_data_o, 32'hCAFEF00D);
      chk("rec_done_stall", stall, 0);
      nxt; mem_op = OP_NONE;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
